packet_tx: RTL and testbench

Packet transmitter: the producing end of the data_first/data_last/data stream that the sum unit consumes. Software or upstream logic pushes words into an internal FIFO, then issues a send command with a length. The block emits those words as one contiguous framed packet and reports the expected sum for self-checking against the receiver. It sits directly upstream of the sum unit, sharing its clock and reset.

---
 rtl/packet_tx_pkg.sv | 27 ++
 rtl/packet_fifo.sv | 72 +++++++
 rtl/packet_tx.sv | 161 ++++++++++++++++
 tb/tb_packet_tx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_tx_pkg.sv
// Purpose: shared types and constants for the packet transmitter slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package packet_tx_pkg;

    // Default data word width. Matches the downstream sum unit.
    localparam int NOF_BITS_DEF   = 32;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int LEN_BITS_DEF   = 8;

    // One-hot transmitter states.
    //   ST_IDLE : bus idle, waiting for a send command
    //   ST_SEND : packet words on the bus
    //   ST_GAP  : one idle bus cycle after a packet; done/exp_sum are valid here
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_GAP  = 3'b100
    } tx_state_t;

    // Width of an occupancy counter for a FIFO of 'depth' entries.
    // It must hold values 0..depth inclusive, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : packet_tx_pkg

// File: rtl/packet_fifo.sv
// Purpose: synchronous single-clock FIFO that buffers packet words ahead of a send.
// Latency: a pushed word is visible at pop_data the cycle after the push; pop_data is the head (show-ahead).
// Backpressure: push while full drops the word; pop while empty is ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (contents discarded)
//   push, push_data      write strobe and word
//   pop                  consume the current head word
//   pop_data             current head word (combinational read)
//   full, empty, count   occupancy status, derived from the registered count
module packet_fifo
    import packet_tx_pkg::*;
#(
    parameter int WIDTH = NOF_BITS_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset: after reset the pointers and count say "empty",
    // so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : packet_fifo

// File: rtl/packet_tx.sv
// Purpose: buffers pushed words and emits them as one framed packet (data_first/data_last/data_out) per send command, reporting the expected receiver sum.
// Latency: send accepted in cycle c -> words on the bus in c+1..c+N, done/exp_sum in c+N+1.
// Backpressure: none on the bus; send only accepted while tx_ready, otherwise rejected (send_err) or ignored mid-packet; pushes into a full FIFO are dropped.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en, wr_data             push a word into the FIFO (allowed in any state)
//   full, count                FIFO status
//   send, send_len             send-command strobe and packet length in words
//   tx_ready                   a legal send will be accepted this cycle
//   send_err                   one-cycle pulse: previous cycle's send was rejected
//   data_first/data_last/data_out/busy   registered packet bus toward the receiver
//   done, exp_sum              one-cycle pulse after the last word, and the packet sum
module packet_tx
    import packet_tx_pkg::*;
#(
    parameter int NOF_BITS   = NOF_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int LEN_BITS   = LEN_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // FIFO write side
    input  logic                         wr_en,
    input  logic [NOF_BITS-1:0]          wr_data,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    // command side
    input  logic                         send,
    input  logic [LEN_BITS-1:0]          send_len,
    output logic                         tx_ready,
    output logic                         send_err,
    // packet bus
    output logic                         data_first,
    output logic                         data_last,
    output logic [NOF_BITS-1:0]          data_out,
    output logic                         busy,
    // completion
    output logic                         done,
    output logic [NOF_BITS:0]            exp_sum
);

    tx_state_t             state;
    logic [LEN_BITS-1:0]   remaining;   // words still to pop after the one currently on the bus
    logic [NOF_BITS:0]     run_sum;

    logic [NOF_BITS-1:0]   fifo_dat;
    logic                  fifo_empty;
    logic                  fifo_pop;

    logic [31:0]           len_ext;
    logic [31:0]           cnt_ext;
    logic                  len_ok;
    logic                  accept;
    logic                  more_words;

    // ------------------------------------------------------------------
    // Word buffer
    // ------------------------------------------------------------------
    packet_fifo #(
        .WIDTH (NOF_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dat),
        .full      (full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign tx_ready = (state == ST_IDLE) || (state == ST_GAP);

    // The length check uses the registered count, i.e. the occupancy before
    // any push happening in this same cycle.
    assign len_ext    = 32'(send_len);
    assign cnt_ext    = 32'(count);
    assign len_ok     = (len_ext != 32'd0) && (len_ext <= cnt_ext);
    assign accept     = tx_ready && send && len_ok;
    assign more_words = (state == ST_SEND) && (remaining != '0);

    // The first word is popped in the accept cycle itself so that it can be
    // registered onto the bus in the very next cycle.
    assign fifo_pop = (accept || more_words) && !fifo_empty;

    // ------------------------------------------------------------------
    // FSM, framing and running sum. All outputs registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            run_sum    <= '0;
            send_err   <= 1'b0;
            data_first <= 1'b0;
            data_last  <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            exp_sum    <= '0;
        end else begin
            // Bus idles and pulses clear unless a branch below says otherwise.
            send_err   <= 1'b0;
            done       <= 1'b0;
            data_first <= 1'b0;
            data_last  <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;

            case (state)
                ST_IDLE, ST_GAP: begin
                    if (send) begin
                        if (len_ok) begin
                            state      <= ST_SEND;
                            data_out   <= fifo_dat;
                            data_first <= 1'b1;
                            data_last  <= (send_len == LEN_BITS'(1));
                            busy       <= 1'b1;
                            remaining  <= send_len - 1'b1;
                            // Clearing the sum and adding the first word in one step.
                            run_sum    <= {1'b0, fifo_dat};
                        end else begin
                            // Rejected command leaves the state as it was.
                            send_err <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_SEND: begin
                    // Commands arriving mid-packet are ignored without an error.
                    if (remaining != '0) begin
                        data_out  <= fifo_dat;
                        data_last <= (remaining == LEN_BITS'(1));
                        busy      <= 1'b1;
                        remaining <= remaining - 1'b1;
                        // NOF_BITS+1 wide, wraps the same way the receiver does.
                        run_sum   <= run_sum + {1'b0, fifo_dat};
                    end else begin
                        // The last word is on the bus now; next cycle is the gap.
                        state   <= ST_GAP;
                        done    <= 1'b1;
                        exp_sum <= run_sum;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : packet_tx

// File: tb/tb_packet_tx.sv
// Purpose: directed self-checking bench for packet_tx (32-bit instance plus an 8-bit instance for sum wrap).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_packet_tx;

    logic clk;
    logic rst_n;

    // 32-bit instance
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic [4:0]  count;
    logic        send;
    logic [7:0]  send_len;
    logic        tx_ready;
    logic        send_err;
    logic        data_first;
    logic        data_last;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic [32:0] exp_sum;

    // 8-bit instance
    logic        wr_en_8;
    logic [7:0]  wr_data_8;
    logic        full_8;
    logic [4:0]  count_8;
    logic        send_8;
    logic [7:0]  send_len_8;
    logic        tx_ready_8;
    logic        send_err_8;
    logic        data_first_8;
    logic        data_last_8;
    logic [7:0]  data_out_8;
    logic        busy_8;
    logic        done_8;
    logic [8:0]  exp_sum_8;

    int checks;
    int errors;

    packet_tx #(.NOF_BITS(32), .FIFO_DEPTH(16), .LEN_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .count(count),
        .send(send), .send_len(send_len), .tx_ready(tx_ready), .send_err(send_err),
        .data_first(data_first), .data_last(data_last), .data_out(data_out), .busy(busy),
        .done(done), .exp_sum(exp_sum)
    );

    packet_tx #(.NOF_BITS(8), .FIFO_DEPTH(16), .LEN_BITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en_8), .wr_data(wr_data_8), .full(full_8), .count(count_8),
        .send(send_8), .send_len(send_len_8), .tx_ready(tx_ready_8), .send_err(send_err_8),
        .data_first(data_first_8), .data_last(data_last_8), .data_out(data_out_8), .busy(busy_8),
        .done(done_8), .exp_sum(exp_sum_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        wr_en = 1'b1;
        wr_data = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (data_first !== 1'b0 || data_last !== 1'b0 || data_out !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: first=%b last=%b out=%0d busy=%b, want all 0", data_first, data_last, data_out, busy);
        end
        checks++;
        if (done !== 1'b0 || send_err !== 1'b0 || exp_sum !== 33'd0) begin
            errors++;
            $display("FAIL reset_status: done=%b send_err=%b exp_sum=%0d, want 0/0/0", done, send_err, exp_sum);
        end
        checks++;
        if (count !== 5'd0 || full !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: count=%0d full=%b tx_ready=%b, want 0/0/1", count, full, tx_ready);
        end
        checks++;
        if (count_8 !== 5'd0 || full_8 !== 1'b0 || tx_ready_8 !== 1'b1 || busy_8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut8: count=%0d full=%b tx_ready=%b busy=%b, want 0/0/1/0", count_8, full_8, tx_ready_8, busy_8);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w [3];
        w = '{32'd3, 32'd5, 32'd7};
        for (int i = 0; i < 3; i++) push_word(w[i]);
        checks++;
        if (count !== 5'd3) begin
            errors++;
            $display("FAIL basic_count_pre: got %0d want 3", count);
        end
        send = 1'b1; send_len = 8'd3;
        tick();
        send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_out !== w[i] || busy !== 1'b1 || data_first !== (i == 0) || data_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_word%0d: out=%0d first=%b last=%b busy=%b, want out=%0d first=%b last=%b busy=1",
                         i, data_out, data_first, data_last, busy, w[i], (i == 0), (i == 2));
            end
            if (i == 0) begin
                checks++;
                if (tx_ready !== 1'b0 || count !== 5'd2) begin
                    errors++;
                    $display("FAIL basic_inflight: tx_ready=%b count=%0d, want 0/2", tx_ready, count);
                end
            end
            if (i == 2) begin
                checks++;
                if (send_err !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_send_in_send: send_err=%b want 0", send_err);
                end
            end
            // a command mid-packet must be ignored silently
            send = (i == 1);
            send_len = 8'd1;
            tick();
        end
        send = 1'b0;
        checks++;
        if (done !== 1'b1 || exp_sum !== 33'd15 || busy !== 1'b0 || data_out !== 32'd0 || tx_ready !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL basic_done: done=%b exp_sum=%0d busy=%b out=%0d tx_ready=%b count=%0d, want 1/15/0/0/1/0",
                     done, exp_sum, busy, data_out, tx_ready, count);
        end
        tick();
        checks++;
        if (done !== 1'b0 || exp_sum !== 33'd15) begin
            errors++;
            $display("FAIL basic_hold: done=%b exp_sum=%0d, want 0/15", done, exp_sum);
        end
    endtask

    task automatic test_single();
        push_word(32'd9);
        send = 1'b1; send_len = 8'd1;
        tick();
        send = 1'b0;
        checks++;
        if (data_out !== 32'd9 || data_first !== 1'b1 || data_last !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_word: out=%0d first=%b last=%b busy=%b, want 9/1/1/1", data_out, data_first, data_last, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || exp_sum !== 33'd9 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b exp_sum=%0d busy=%b, want 1/9/0", done, exp_sum, busy);
        end
    endtask

    task automatic test_wrap8();
        for (int i = 0; i < 3; i++) begin
            wr_en_8 = 1'b1; wr_data_8 = 8'd255;
            tick();
        end
        wr_en_8 = 1'b0;
        send_8 = 1'b1; send_len_8 = 8'd3;
        tick();
        send_8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_out_8 !== 8'd255 || data_first_8 !== (i == 0) || data_last_8 !== (i == 2)) begin
                errors++;
                $display("FAIL wrap8_word%0d: out=%0d first=%b last=%b, want 255/%b/%b", i, data_out_8, data_first_8, data_last_8, (i == 0), (i == 2));
            end
            tick();
        end
        checks++;
        if (done_8 !== 1'b1 || exp_sum_8 !== 9'h0FD || count_8 !== 5'd0) begin
            errors++;
            $display("FAIL wrap8_sum: done=%b exp_sum=%h count=%0d, want 1/0fd/0", done_8, exp_sum_8, count_8);
        end
    endtask

    task automatic test_send_err();
        push_word(32'd1);
        push_word(32'd2);
        send = 1'b1; send_len = 8'd0;
        tick();
        send = 1'b0;
        checks++;
        if (send_err !== 1'b1 || busy !== 1'b0 || data_first !== 1'b0 || count !== 5'd2) begin
            errors++;
            $display("FAIL err_len0: send_err=%b busy=%b first=%b count=%0d, want 1/0/0/2", send_err, busy, data_first, count);
        end
        tick();
        checks++;
        if (send_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: send_err=%b want 0", send_err);
        end
        send = 1'b1; send_len = 8'd4;
        tick();
        send = 1'b0;
        checks++;
        if (send_err !== 1'b1 || busy !== 1'b0 || count !== 5'd2 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_toolong: send_err=%b busy=%b count=%0d tx_ready=%b, want 1/0/2/1", send_err, busy, count, tx_ready);
        end
        // drain the two words
        send = 1'b1; send_len = 8'd2;
        tick();
        send = 1'b0;
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || exp_sum !== 33'd3 || count !== 5'd0) begin
            errors++;
            $display("FAIL err_drain: done=%b exp_sum=%0d count=%0d, want 1/3/0", done, exp_sum, count);
        end
    endtask

    task automatic test_full_back_to_back();
        for (int i = 1; i <= 16; i++) push_word(32'(i));
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: count=%0d full=%b, want 16/1", count, full);
        end
        push_word(32'd99);
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: count=%0d full=%b, want 16/1", count, full);
        end
        send = 1'b1; send_len = 8'd2;
        tick();
        send = 1'b0;
        checks++;
        if (data_out !== 32'd1 || data_first !== 1'b1 || full !== 1'b0 || count !== 5'd15) begin
            errors++;
            $display("FAIL b2b_p1w0: out=%0d first=%b full=%b count=%0d, want 1/1/0/15", data_out, data_first, full, count);
        end
        tick();
        checks++;
        if (data_out !== 32'd2 || data_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_p1w1: out=%0d last=%b, want 2/1", data_out, data_last);
        end
        tick();
        checks++;
        if (done !== 1'b1 || exp_sum !== 33'd3 || busy !== 1'b0 || data_out !== 32'd0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: done=%b exp_sum=%0d busy=%b out=%0d tx_ready=%b, want 1/3/0/0/1", done, exp_sum, busy, data_out, tx_ready);
        end
        send = 1'b1; send_len = 8'd2;
        tick();
        send = 1'b0;
        checks++;
        if (data_out !== 32'd3 || data_first !== 1'b1 || busy !== 1'b1 || send_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_p2w0: out=%0d first=%b busy=%b send_err=%b, want 3/1/1/0", data_out, data_first, busy, send_err);
        end
        tick();
        checks++;
        if (data_out !== 32'd4 || data_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_p2w1: out=%0d last=%b, want 4/1", data_out, data_last);
        end
        tick();
        checks++;
        if (done !== 1'b1 || exp_sum !== 33'd7 || count !== 5'd12) begin
            errors++;
            $display("FAIL b2b_done2: done=%b exp_sum=%0d count=%0d, want 1/7/12", done, exp_sum, count);
        end
    endtask

    task automatic test_push_pop();
        // FIFO holds 5..16; send all of it while pushing 50 mid-packet
        send = 1'b1; send_len = 8'd12;
        tick();
        send = 1'b0;
        checks++;
        if (data_out !== 32'd5 || count !== 5'd11) begin
            errors++;
            $display("FAIL pp_first: out=%0d count=%0d, want 5/11", data_out, count);
        end
        push_word(32'd50);
        checks++;
        if (data_out !== 32'd6 || count !== 5'd11) begin
            errors++;
            $display("FAIL pp_same_cycle: out=%0d count=%0d, want 6/11", data_out, count);
        end
        for (int k = 7; k <= 16; k++) begin
            tick();
            checks++;
            if (data_out !== 32'(k) || data_last !== (k == 16) || busy !== 1'b1) begin
                errors++;
                $display("FAIL pp_word%0d: out=%0d last=%b busy=%b, want %0d/%b/1", k, data_out, data_last, busy, k, (k == 16));
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || exp_sum !== 33'd126 || count !== 5'd1) begin
            errors++;
            $display("FAIL pp_done: done=%b exp_sum=%0d count=%0d, want 1/126/1", done, exp_sum, count);
        end
    endtask

    task automatic test_reset_mid();
        push_word(32'd10);
        push_word(32'd20);
        push_word(32'd30);
        push_word(32'd40);
        send = 1'b1; send_len = 8'd5;
        tick();
        send = 1'b0;
        tick();
        tick();
        checks++;
        if (data_out !== 32'd20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_third_word: out=%0d busy=%b, want 20/1", data_out, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || data_out !== 32'd0 || data_first !== 1'b0 || data_last !== 1'b0 ||
            done !== 1'b0 || exp_sum !== 33'd0 || count !== 5'd0 || full !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: busy=%b out=%0d first=%b last=%b done=%b exp_sum=%0d count=%0d full=%b tx_ready=%b, want reset values",
                     busy, data_out, data_first, data_last, done, exp_sum, count, full, tx_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (count !== 5'd0 || busy !== 1'b0 || data_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: count=%0d busy=%b last=%b, want 0/0/0", count, busy, data_last);
        end
        push_word(32'd6);
        push_word(32'd8);
        send = 1'b1; send_len = 8'd2;
        tick();
        send = 1'b0;
        checks++;
        if (data_out !== 32'd6 || data_first !== 1'b1 || data_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_new_w0: out=%0d first=%b last=%b, want 6/1/0", data_out, data_first, data_last);
        end
        tick();
        checks++;
        if (data_out !== 32'd8 || data_first !== 1'b0 || data_last !== 1'b1) begin
            errors++;
            $display("FAIL rst_new_w1: out=%0d first=%b last=%b, want 8/0/1", data_out, data_first, data_last);
        end
        tick();
        checks++;
        if (done !== 1'b1 || exp_sum !== 33'd14 || count !== 5'd0) begin
            errors++;
            $display("FAIL rst_new_done: done=%b exp_sum=%0d count=%0d, want 1/14/0", done, exp_sum, count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_data = '0; send = 1'b0; send_len = '0;
        wr_en_8 = 1'b0; wr_data_8 = '0; send_8 = 1'b0; send_len_8 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        test_reset();
        test_basic();
        test_single();
        test_wrap8();
        test_send_err();
        test_full_back_to_back();
        test_push_pop();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_packet_tx
